// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

    typedef enum logic [1:0] {
        S_SIZE = 2'd0,
        S_DATA = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } loader_state_t;

    // Length header is a 4-byte big-endian byte count.
    localparam int SIZE_BYTES = 4;

    // Bit positions inside the sticky err vector.
    localparam int ERR_TIMEOUT  = 0;
    localparam int ERR_OVERFLOW = 1;

endpackage

// File: rtl/program_loader.sv
// Boot-time program download receiver: takes a big-endian byte count followed
// by the program bytes from the UART, packs them little-endian into 32-bit
// words and writes them sequentially into instruction memory. done releases
// the CPU from reset; err reports timeout / memory overflow.
module program_loader
    import loader_pkg::*;
#(
    parameter int          ADDR_W     = 12,
    parameter logic [31:0] BASE_WADDR = 32'd0,
    parameter logic [31:0] TIMEOUT    = 32'd1_000_000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              done,
    output logic [1:0]        err
);

    // One past the last valid word address, kept one bit wider than any
    // address sum so the comparison never wraps.
    localparam logic [32:0] CAPACITY  = 33'd1 << ADDR_W;
    localparam logic [31:0] SIZE_LAST = 32'(SIZE_BYTES - 1);

    loader_state_t state;
    loader_state_t state_next;

    logic [31:0] size;       // shifted-in byte count
    logic [31:0] size_cnt;   // header bytes received so far
    logic [31:0] byte_cnt;   // byte position inside the current word
    logic [31:0] idle_cnt;   // cycles since the last accepted byte
    logic [29:0] widx;       // words consumed so far (written or dropped)
    logic [29:0] nwords;
    logic [23:0] word;       // low three bytes of the word being packed

    logic [31:0] size_word;
    logic [29:0] widx_inc;
    logic [32:0] waddr_full;
    logic        size_last;
    logic        word_last;
    logic        idle_run;
    logic        timeout_hit;
    logic        write_ok;
    logic        write_ovf;

    // Word count is fixed once the header is complete; the low two bits of
    // the byte count are ignored because the host always sends whole words.
    assign nwords     = size[31:2];
    assign size_word  = {size[23:0], rx_data};
    assign widx_inc   = widx + 30'd1;
    assign waddr_full = {3'b000, widx} + {1'b0, BASE_WADDR};

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_SIZE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; S_DONE and S_ERR are terminal until reset
    always_comb begin
        state_next = state;
        case (state)
            S_SIZE: begin
                if (timeout_hit) begin
                    state_next = S_ERR;
                end else if (size_last) begin
                    state_next = (size_word[31:2] == 30'd0) ? S_DONE : S_DATA;
                end
            end
            S_DATA: begin
                if (timeout_hit) begin
                    state_next = S_ERR;
                end else if (word_last && (widx_inc == nwords)) begin
                    state_next = S_DONE;
                end
            end
            default: state_next = state;
        endcase
    end

    // Per-cycle control decode: byte events, timeout and write qualification
    always_comb begin
        size_last   = (state == S_SIZE) && rx_valid && (size_cnt == SIZE_LAST);
        word_last   = (state == S_DATA) && rx_valid && (byte_cnt == 32'd3);
        idle_run    = ((state == S_SIZE) && (size_cnt != 32'd0)) || (state == S_DATA);
        // A byte arriving on the expiry cycle wins over the timeout.
        timeout_hit = idle_run && !rx_valid && (idle_cnt == TIMEOUT);
        write_ok    = word_last && (waddr_full < CAPACITY);
        write_ovf   = word_last && (waddr_full >= CAPACITY);
    end

    // Header shifter, word packer and progress counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            size     <= 32'd0;
            size_cnt <= 32'd0;
            byte_cnt <= 32'd0;
            idle_cnt <= 32'd0;
            widx     <= 30'd0;
            word     <= 24'd0;
        end else begin
            if ((state == S_SIZE) && rx_valid) begin
                size     <= size_word;
                size_cnt <= size_cnt + 32'd1;
            end

            if ((state == S_DATA) && rx_valid) begin
                byte_cnt <= word_last ? 32'd0 : byte_cnt + 32'd1;
                case (byte_cnt[1:0])
                    2'd0:    word[7:0]   <= rx_data;
                    2'd1:    word[15:8]  <= rx_data;
                    2'd2:    word[23:16] <= rx_data;
                    default: ;
                endcase
            end

            // Overflowed words still advance widx so the stream stays aligned.
            if (word_last) begin
                widx <= widx_inc;
            end

            if (rx_valid || !idle_run) begin
                idle_cnt <= 32'd0;
            end else if (idle_cnt != TIMEOUT) begin
                idle_cnt <= idle_cnt + 32'd1;
            end
        end
    end

    // Registered memory write port and sticky status outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= 32'd0;
            done       <= 1'b0;
            err        <= 2'b00;
        end else begin
            imem_we <= write_ok;
            if (write_ok) begin
                imem_waddr <= waddr_full[ADDR_W-1:0];
                imem_wdata <= {rx_data, word};
            end
            if (write_ovf) begin
                err[ERR_OVERFLOW] <= 1'b1;
            end
            if (timeout_hit) begin
                err[ERR_TIMEOUT] <= 1'b1;
            end
            done <= (state_next == S_DONE);
        end
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time receiver for the host program-download protocol. It consumes bytes from the UART receiver: a 4-byte big-endian byte count, then that many program bytes. It packs them little-endian into 32-bit words, writes them sequentially into instruction memory, and holds the CPU in reset until the load completes. It sits between `uart_rx` and the instruction-memory write port inside `top`.

## Interface
Parameters:
- `ADDR_W`, 12: instruction-memory word-address width; capacity is 2^ADDR_W words.
- `BASE_WADDR`, 0: word address of the first program word.
- `TIMEOUT`, 32'd1_000_000: maximum idle clk cycles between bytes once a transfer has started.

Ports (one clock domain; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `rstn`  in  1  asynchronous active-low reset.
- `rx_data`  in  8  byte from `uart_rx`.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in that cycle.
- `imem_we`  out  1  one-cycle instruction-memory write strobe.
- `imem_waddr`  out  ADDR_W  word address for the write.
- `imem_wdata`  out  32  word to write.
- `done`  out  1  load complete; sticky until reset; also serves as CPU reset release.
- `err`  out  2  sticky error flags: bit0 = timeout, bit1 = overflow.

## Operation
- States: `S_SIZE`, `S_DATA`, `S_DONE`, `S_ERR`.
- Reset state is `S_SIZE` with the byte counter cleared.
- **S_SIZE**
  - Shift each accepted byte into `size`: `size <= {size[23:0], rx_data}`.
  - After the 4th byte, set `nwords = size[31:2]`. The low 2 bits of `size` are ignored; the host always sends a multiple of 4.
  - If `nwords == 0`, go to `S_DONE`; otherwise go to `S_DATA`.
- **S_DATA**
  - Byte k of a word (k = 0..3) goes to `word[8k+7:8k]`.
  - On the 4th byte, issue a write of `{rx_data, word[23:0]}` to `BASE_WADDR + widx` (ADDR_W-bit wrap), then increment `widx`.
  - When `widx` reaches `nwords` after a write, go to `S_DONE`.
- **Overflow**
  - Applies when `BASE_WADDR + widx >= 2^ADDR_W`: suppress `imem_we` and set `err[1]`.
  - Keep consuming bytes so the host stream stays aligned; still reach `S_DONE`.
- **Timeout**
  - An idle counter runs in `S_SIZE` (after ≥1 byte) and in `S_DATA`. It clears on every `rx_valid`.
  - On reaching `TIMEOUT`, set `err[0]` and go to `S_ERR`.
- **S_ERR**: terminal. `done` stays 0 and the CPU stays in reset.
- **S_DONE**: terminal. `rx_valid` is ignored; `done = 1`.
- Bytes arriving in `S_DONE` or `S_ERR` are dropped silently.
- All counters are 32-bit except `widx`, which is 30-bit. No arithmetic may saturate silently.

## Timing
- Reset values: `imem_we = 0`, `imem_waddr = 0`, `imem_wdata = 0`, `done = 0`, `err = 2'b00`.
- All outputs are registered.
- `imem_we` goes high exactly 1 cycle after the `rx_valid` of the 4th byte of a word, for 1 cycle. `imem_waddr` and `imem_wdata` are valid in that same cycle and hold until the next write.
- `done` rises in the same cycle as the final `imem_we`. For `nwords == 0`, it rises 1 cycle after the 4th size byte.
- `rx_valid` can occur in back-to-back cycles; each strobe is accepted, so there is no backpressure.
- A write strobe coinciding with a new `rx_valid` has no effect on acceptance.
- The timeout fires on the cycle the idle count equals `TIMEOUT`. If a byte arrives in that same cycle, the byte wins and the counter clears.
- `rstn` assertion mid-transfer aborts immediately: all state and outputs return to reset values asynchronously, and memory contents are left as written.

## Structure
- Shared package `loader_pkg` holds:
  - the `loader_state_t` enum;
  - `SIZE_BYTES = 4`;
  - the error-bit index constants `ERR_TIMEOUT = 0` and `ERR_OVERFLOW = 1`.
- No sub-module needed: a single FSM plus a byte packer.
- `top` gates the CPU reset with `rstn & done`.

## Test plan
- Size `00 00 00 6C` (108) then 108 bytes, each `i & 8'hFF`:
  - 27 writes, addresses 0..26;
  - word 0 = `32'h03020100`, word 26 = `32'h6B6A6968`;
  - `done` rises with the 27th write.
- Size `00 00 00 00` -> no `imem_we`; `done = 1` one cycle after the 4th byte.
- Back-to-back `rx_valid` for size 8 plus 8 bytes `11..88` -> writes `32'h44332211` @0 and `32'h88776655` @1.
- `ADDR_W = 2`, size 24 -> 4 writes, no writes for words 4–5, `err = 2'b10`, `done = 1`.
- `TIMEOUT = 100`; send 2 size bytes, then idle 100 cycles -> `err = 2'b01`; `done` stays 0; later bytes produce no writes.
- Assert `rstn` low after 6 of 8 data bytes, then a full valid reload of size 4, bytes `DE AD BE EF` -> write `32'hEFBEADDE` @0, then `done`.
